// File: rtl/jtag_tap_controller_pkg.sv
// Shared TAP definitions: the 16 IEEE 1149.1 controller states, the BYPASS
// opcode, the default IR capture pattern and the state transition function.
package jtag_tap_controller_pkg;

   typedef enum logic [3:0] {
      TEST_LOGIC_RESET = 4'd0,
      RUN_TEST_IDLE    = 4'd1,
      SELECT_DR_SCAN   = 4'd2,
      CAPTURE_DR       = 4'd3,
      SHIFT_DR         = 4'd4,
      EXIT1_DR         = 4'd5,
      PAUSE_DR         = 4'd6,
      EXIT2_DR         = 4'd7,
      UPDATE_DR        = 4'd8,
      SELECT_IR_SCAN   = 4'd9,
      CAPTURE_IR       = 4'd10,
      SHIFT_IR         = 4'd11,
      EXIT1_IR         = 4'd12,
      PAUSE_IR         = 4'd13,
      EXIT2_IR         = 4'd14,
      UPDATE_IR        = 4'd15
   } jtag_tap_state_t;

   localparam int JTAG_IR_WIDTH = 4;
   localparam logic [JTAG_IR_WIDTH-1:0] JTAG_BYPASS         = '1;
   localparam logic [JTAG_IR_WIDTH-1:0] JTAG_IR_CAPTURE_VAL = 4'b0001;

   function automatic jtag_tap_state_t jtag_next_state(input jtag_tap_state_t state,
                                                       input logic tms);
      jtag_tap_state_t next;
      next = state;
      case (state)
         TEST_LOGIC_RESET: next = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
         RUN_TEST_IDLE:    next = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
         SELECT_DR_SCAN:   next = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
         CAPTURE_DR:       next = tms ? EXIT1_DR         : SHIFT_DR;
         SHIFT_DR:         next = tms ? EXIT1_DR         : SHIFT_DR;
         EXIT1_DR:         next = tms ? UPDATE_DR        : PAUSE_DR;
         PAUSE_DR:         next = tms ? EXIT2_DR         : PAUSE_DR;
         EXIT2_DR:         next = tms ? UPDATE_DR        : SHIFT_DR;
         UPDATE_DR:        next = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
         SELECT_IR_SCAN:   next = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
         CAPTURE_IR:       next = tms ? EXIT1_IR         : SHIFT_IR;
         SHIFT_IR:         next = tms ? EXIT1_IR         : SHIFT_IR;
         EXIT1_IR:         next = tms ? UPDATE_IR        : PAUSE_IR;
         PAUSE_IR:         next = tms ? EXIT2_IR         : PAUSE_IR;
         EXIT2_IR:         next = tms ? UPDATE_IR        : SHIFT_IR;
         UPDATE_IR:        next = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
         default:          next = TEST_LOGIC_RESET;
      endcase
      return next;
   endfunction

endpackage

// File: rtl/jtag_tap_controller_sync.sv
// Per-bit two-flop synchronizer used to bring the asynchronous JTAG pins
// into the clk domain.
module jtag_tap_controller_sync #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_reg;
   logic [WIDTH-1:0] sync_reg;

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            meta_reg[gi] <= 1'b0;
            sync_reg[gi] <= 1'b0;
         end else begin
            meta_reg[gi] <= d[gi];
            sync_reg[gi] <= meta_reg[gi];
         end
      end
   end

   assign q = sync_reg;

endmodule

// File: rtl/jtag_tap_controller.sv
// Device-side JTAG TAP controller running in the clk domain; tck is
// oversampled and its synchronized edges advance the TAP state machine.
module jtag_tap_controller
   import jtag_tap_controller_pkg::*;
#(
   parameter int INSTRUCTION_WIDTH = 4,
   parameter int DATA_WIDTH        = 32,
   parameter logic [INSTRUCTION_WIDTH-1:0] IR_CAPTURE_VAL =
      INSTRUCTION_WIDTH'(JTAG_IR_CAPTURE_VAL)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         jtag_tck,
   input  logic                         jtag_tms,
   input  logic                         jtag_trst,
   input  logic                         jtag_tdo,
   output logic                         jtag_tdi,
   output logic [INSTRUCTION_WIDTH-1:0] jtag_instruction,
   input  logic [DATA_WIDTH-1:0]        data_capture_val,
   output logic                         capture_dr,
   output logic                         update_dr,
   output logic [DATA_WIDTH-1:0]        data_update_val,
   output logic                         update_ir
);

   localparam logic [INSTRUCTION_WIDTH-1:0] BYPASS_INSTR = '1;

   logic [3:0] pins_sync;
   logic       sync_tck;
   logic       sync_tms;
   logic       sync_tdo;
   logic       sync_trst;
   logic       tck_prev_reg;
   logic       tck_rise;
   logic       tck_fall;

   jtag_tap_state_t               state_reg, state_next;
   logic [INSTRUCTION_WIDTH-1:0]  ir_shift_reg, ir_shift_next;
   logic [INSTRUCTION_WIDTH-1:0]  instruction_reg, instruction_next;
   logic [DATA_WIDTH-1:0]         dr_shift_reg, dr_shift_next;
   logic [DATA_WIDTH-1:0]         data_update_reg, data_update_next;
   logic                          bypass_reg, bypass_next;
   logic                          tdi_reg, tdi_next;
   logic                          capture_dr_reg, capture_dr_next;
   logic                          update_dr_reg, update_dr_next;
   logic                          update_ir_reg, update_ir_next;
   logic                          is_bypass;

   jtag_tap_controller_sync #(
      .WIDTH(4)
   ) u_sync (
      .clk  (clk),
      .reset(reset),
      .d    ({jtag_trst, jtag_tdo, jtag_tms, jtag_tck}),
      .q    (pins_sync)
   );

   assign sync_tck  = pins_sync[0];
   assign sync_tms  = pins_sync[1];
   assign sync_tdo  = pins_sync[2];
   assign sync_trst = pins_sync[3];

   assign tck_rise  = sync_tck & ~tck_prev_reg;
   assign tck_fall  = ~sync_tck & tck_prev_reg;
   assign is_bypass = (instruction_reg == BYPASS_INSTR);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tck_prev_reg    <= 1'b0;
         state_reg       <= TEST_LOGIC_RESET;
         ir_shift_reg    <= '0;
         instruction_reg <= BYPASS_INSTR;
         dr_shift_reg    <= '0;
         data_update_reg <= '0;
         bypass_reg      <= 1'b0;
         tdi_reg         <= 1'b0;
         capture_dr_reg  <= 1'b0;
         update_dr_reg   <= 1'b0;
         update_ir_reg   <= 1'b0;
      end else begin
         tck_prev_reg    <= sync_tck;
         state_reg       <= state_next;
         ir_shift_reg    <= ir_shift_next;
         instruction_reg <= instruction_next;
         dr_shift_reg    <= dr_shift_next;
         data_update_reg <= data_update_next;
         bypass_reg      <= bypass_next;
         tdi_reg         <= tdi_next;
         capture_dr_reg  <= capture_dr_next;
         update_dr_reg   <= update_dr_next;
         update_ir_reg   <= update_ir_next;
      end
   end

   // Register actions are keyed on the state before the transition, so the
   // edge that leaves SHIFT_* via EXIT1 still shifts its final bit.
   always_comb begin
      state_next       = state_reg;
      ir_shift_next    = ir_shift_reg;
      instruction_next = instruction_reg;
      dr_shift_next    = dr_shift_reg;
      data_update_next = data_update_reg;
      bypass_next      = bypass_reg;
      tdi_next         = tdi_reg;
      capture_dr_next  = 1'b0;
      update_dr_next   = 1'b0;
      update_ir_next   = 1'b0;

      if (sync_trst) begin
         // Host test reset overrides any tck edge seen in the same cycle.
         state_next       = TEST_LOGIC_RESET;
         instruction_next = BYPASS_INSTR;
      end else begin
         if (tck_rise) begin
            state_next = jtag_next_state(state_reg, sync_tms);
            case (state_reg)
               TEST_LOGIC_RESET: instruction_next = BYPASS_INSTR;
               CAPTURE_IR:       ir_shift_next = IR_CAPTURE_VAL;
               SHIFT_IR:         ir_shift_next = {sync_tdo, ir_shift_reg[INSTRUCTION_WIDTH-1:1]};
               UPDATE_IR: begin
                  instruction_next = ir_shift_reg;
                  update_ir_next   = 1'b1;
               end
               CAPTURE_DR: begin
                  if (is_bypass) begin
                     bypass_next = 1'b0;
                  end else begin
                     dr_shift_next   = data_capture_val;
                     capture_dr_next = 1'b1;
                  end
               end
               SHIFT_DR: begin
                  if (is_bypass) begin
                     bypass_next = sync_tdo;
                  end else begin
                     dr_shift_next = {sync_tdo, dr_shift_reg[DATA_WIDTH-1:1]};
                  end
               end
               UPDATE_DR: begin
                  if (!is_bypass) begin
                     data_update_next = dr_shift_reg;
                     update_dr_next   = 1'b1;
                  end
               end
               default: ;
            endcase
         end

         if (tck_fall) begin
            case (state_reg)
               SHIFT_IR: tdi_next = ir_shift_reg[0];
               SHIFT_DR: tdi_next = is_bypass ? bypass_reg : dr_shift_reg[0];
               default:  tdi_next = 1'b0;
            endcase
         end
      end
   end

   assign jtag_tdi         = tdi_reg;
   assign jtag_instruction = instruction_reg;
   assign capture_dr       = capture_dr_reg;
   assign update_dr        = update_dr_reg;
   assign update_ir        = update_ir_reg;
   assign data_update_val  = data_update_reg;

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Host-side bench: bit-bangs the JTAG pins and checks every tck period
// against a behavioural TAP model plus literal scan results.
module tb_jtag_tap_controller;

   localparam int IW   = 4;
   localparam int DW   = 32;
   localparam int HALF = 6;

   localparam int S_RESET = 0, S_IDLE = 1, S_SELDR = 2, S_SELIR = 9;
   localparam int DR_BASE = 3, IR_BASE = 10;
   localparam int R_CAP = 0, R_SHIFT = 1, R_EXIT1 = 2, R_PAUSE = 3, R_EXIT2 = 4, R_UPD = 5;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          jtag_tck = 1'b0;
   logic          jtag_tms = 1'b0;
   logic          jtag_trst = 1'b0;
   logic          jtag_tdo = 1'b0;
   logic          jtag_tdi;
   logic [IW-1:0] jtag_instruction;
   logic [DW-1:0] data_capture_val = '0;
   logic          capture_dr;
   logic          update_dr;
   logic [DW-1:0] data_update_val;
   logic          update_ir;

   int errors = 0;
   int checks = 0;
   int tot_cap = 0;
   int tot_udr = 0;
   int tot_uir = 0;

   // Behavioural model of the device as seen from the pins.
   int            m_state = S_RESET;
   logic [IW-1:0] m_ir    = '0;
   logic [IW-1:0] m_instr = '1;
   logic [DW-1:0] m_dr    = '0;
   logic [DW-1:0] m_dupd  = '0;
   logic          m_byp   = 1'b0;
   logic          m_tdi   = 1'b0;

   always #5 clk = ~clk;

   jtag_tap_controller #(
      .INSTRUCTION_WIDTH(IW),
      .DATA_WIDTH       (DW),
      .IR_CAPTURE_VAL   (4'b0001)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .jtag_tck        (jtag_tck),
      .jtag_tms        (jtag_tms),
      .jtag_trst       (jtag_trst),
      .jtag_tdo        (jtag_tdo),
      .jtag_tdi        (jtag_tdi),
      .jtag_instruction(jtag_instruction),
      .data_capture_val(data_capture_val),
      .capture_dr      (capture_dr),
      .update_dr       (update_dr),
      .data_update_val (data_update_val),
      .update_ir       (update_ir)
   );

   // Counting high cycles (not edges) also catches pulses wider than one clk.
   always @(negedge clk) begin
      tot_cap <= tot_cap + (capture_dr ? 1 : 0);
      tot_udr <= tot_udr + (update_dr ? 1 : 0);
      tot_uir <= tot_uir + (update_ir ? 1 : 0);
   end

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic int next_state(input int s, input logic tms);
      int b, r;
      if (s == S_RESET) return tms ? S_RESET : S_IDLE;
      if (s == S_IDLE)  return tms ? S_SELDR : S_IDLE;
      if (s == S_SELDR) return tms ? S_SELIR : DR_BASE;
      if (s == S_SELIR) return tms ? S_RESET : IR_BASE;
      b = (s >= IR_BASE) ? IR_BASE : DR_BASE;
      r = s - b;
      case (r)
         R_CAP, R_SHIFT: return b + (tms ? R_EXIT1 : R_SHIFT);
         R_EXIT1:        return b + (tms ? R_UPD : R_PAUSE);
         R_PAUSE:        return b + (tms ? R_EXIT2 : R_PAUSE);
         R_EXIT2:        return b + (tms ? R_UPD : R_SHIFT);
         default:        return tms ? S_SELDR : S_IDLE;
      endcase
   endfunction

   task automatic model_rise(input logic tms, input logic tdo,
                             output logic e_cap, output logic e_udr, output logic e_uir);
      logic byp;
      byp   = (m_instr == '1);
      e_cap = 1'b0;
      e_udr = 1'b0;
      e_uir = 1'b0;
      if (m_state == S_RESET) m_instr = '1;
      else if (m_state == IR_BASE + R_CAP)   m_ir = 4'b0001;
      else if (m_state == IR_BASE + R_SHIFT) m_ir = {tdo, m_ir[IW-1:1]};
      else if (m_state == IR_BASE + R_UPD) begin
         m_instr = m_ir;
         e_uir   = 1'b1;
      end else if (m_state == DR_BASE + R_CAP) begin
         if (byp) m_byp = 1'b0;
         else begin
            m_dr  = data_capture_val;
            e_cap = 1'b1;
         end
      end else if (m_state == DR_BASE + R_SHIFT) begin
         if (byp) m_byp = tdo;
         else m_dr = {tdo, m_dr[DW-1:1]};
      end else if (m_state == DR_BASE + R_UPD && !byp) begin
         m_dupd = m_dr;
         e_udr  = 1'b1;
      end
      m_state = next_state(m_state, tms);
   endtask

   function automatic logic model_out();
      if (m_state == IR_BASE + R_SHIFT) return m_ir[0];
      if (m_state == DR_BASE + R_SHIFT) return (m_instr == '1) ? m_byp : m_dr[0];
      return 1'b0;
   endfunction

   // One tck period; tdi is sampled just before the rising edge, as a host would.
   task automatic tick(input logic tms_v, input logic tdo_v, input logic trst_v,
                       output logic tdi_got);
      int   c0, u0, i0;
      logic e_cap, e_udr, e_uir;
      jtag_tms = tms_v;
      jtag_tdo = tdo_v;
      wait_clk(2);
      jtag_trst = trst_v;
      wait_clk(HALF - 2);
      tdi_got = jtag_tdi;
      check("tdi", 64'(jtag_tdi), 64'(m_tdi));
      c0 = tot_cap;
      u0 = tot_udr;
      i0 = tot_uir;
      if (trst_v) begin
         m_state = S_RESET;
         m_instr = '1;
         e_cap = 1'b0;
         e_udr = 1'b0;
         e_uir = 1'b0;
      end else begin
         model_rise(tms_v, tdo_v, e_cap, e_udr, e_uir);
      end
      jtag_tck = 1'b1;
      wait_clk(HALF);
      check("capture_dr_pulse", 64'(tot_cap - c0), 64'(e_cap));
      check("update_dr_pulse", 64'(tot_udr - u0), 64'(e_udr));
      check("update_ir_pulse", 64'(tot_uir - i0), 64'(e_uir));
      check("instruction", 64'(jtag_instruction), 64'(m_instr));
      check("data_update_val", 64'(data_update_val), 64'(m_dupd));
      jtag_tck = 1'b0;
      if (!trst_v) m_tdi = model_out();
   endtask

   // From IDLE: load an instruction, return the captured IR; ends in IDLE.
   task automatic scan_ir(input logic [IW-1:0] val, output logic [IW-1:0] got);
      logic b;
      got = '0;
      tick(1'b1, 1'b0, 1'b0, b);
      tick(1'b1, 1'b0, 1'b0, b);
      tick(1'b0, 1'b0, 1'b0, b);
      tick(1'b0, 1'b0, 1'b0, b);
      for (int i = 0; i < IW; i++) begin
         tick(i == IW - 1, val[i], 1'b0, b);
         got[i] = b;
      end
      tick(1'b1, 1'b0, 1'b0, b);
      tick(1'b0, 1'b0, 1'b0, b);
   endtask

   // From IDLE: shift nbits of val, optionally pausing 10 tck after bit 15; ends in IDLE.
   task automatic scan_dr(input logic [DW-1:0] val, input int nbits, input bit pause,
                          output logic [DW-1:0] got);
      logic b;
      got = '0;
      tick(1'b1, 1'b0, 1'b0, b);
      tick(1'b0, 1'b0, 1'b0, b);
      tick(1'b0, 1'b0, 1'b0, b);
      for (int i = 0; i < nbits; i++) begin
         tick((i == nbits - 1) || (pause && i == 15), val[i], 1'b0, b);
         got[i] = b;
         if (pause && i == 15) begin
            tick(1'b0, 1'b0, 1'b0, b);
            repeat (10) tick(1'b0, 1'b0, 1'b0, b);
            tick(1'b1, 1'b0, 1'b0, b);
            tick(1'b0, 1'b0, 1'b0, b);
         end
      end
      tick(1'b1, 1'b0, 1'b0, b);
      tick(1'b0, 1'b0, 1'b0, b);
   endtask

   initial begin
      logic [IW-1:0] ir_got;
      logic [DW-1:0] dr_got;
      logic          b;
      int            c0, u0, i0;

      wait_clk(3);
      check("rst_instruction", 64'(jtag_instruction), 64'hF);
      check("rst_tdi", 64'(jtag_tdi), 64'h0);
      check("rst_pulses", 64'({capture_dr, update_dr, update_ir}), 64'h0);
      check("rst_data_update_val", 64'(data_update_val), 64'h0);
      reset = 1'b0;
      wait_clk(20);
      check("post_rst_instruction", 64'(jtag_instruction), 64'hF);
      check("post_rst_tdi", 64'(jtag_tdi), 64'h0);
      check("post_rst_pulse_count", 64'(tot_cap + tot_udr + tot_uir), 64'h0);

      tick(1'b0, 1'b0, 1'b0, b);

      // IR load
      i0 = tot_uir;
      scan_ir(4'h3, ir_got);
      check("ir_capture_read", 64'(ir_got), 64'h1);
      check("ir_loaded", 64'(jtag_instruction), 64'h3);
      check("ir_update_count", 64'(tot_uir - i0), 64'h1);

      // DR exchange
      data_capture_val = 32'hDEADBEEF;
      c0 = tot_cap;
      u0 = tot_udr;
      scan_dr(32'h12345678, 32, 1'b0, dr_got);
      check("dr_read", 64'(dr_got), 64'hDEADBEEF);
      check("dr_update_val", 64'(data_update_val), 64'h12345678);
      check("dr_capture_count", 64'(tot_cap - c0), 64'h1);
      check("dr_update_count", 64'(tot_udr - u0), 64'h1);

      // Pause in the middle of a DR scan
      data_capture_val = 32'h0F1E2D3C;
      scan_dr(32'hCAFEF00D, 32, 1'b1, dr_got);
      check("pause_read", 64'(dr_got), 64'h0F1E2D3C);
      check("pause_update_val", 64'(data_update_val), 64'hCAFEF00D);

      // trst in the middle of SHIFT_DR
      u0 = tot_udr;
      tick(1'b1, 1'b0, 1'b0, b);
      tick(1'b0, 1'b0, 1'b0, b);
      tick(1'b0, 1'b0, 1'b0, b);
      for (int i = 0; i < 10; i++) tick(1'b0, 1'($urandom_range(0, 1)), 1'b0, b);
      tick(1'b0, 1'b0, 1'b1, b);
      tick(1'b0, 1'b0, 1'b1, b);
      check("trst_instruction", 64'(jtag_instruction), 64'hF);
      check("trst_no_update", 64'(tot_udr - u0), 64'h0);
      check("trst_update_val_kept", 64'(data_update_val), 64'hCAFEF00D);
      tick(1'b0, 1'b0, 1'b0, b);
      tick(1'b0, 1'b0, 1'b0, b);

      // Bypass: tdi lags tdo by one bit and no DR strobes fire
      scan_ir(4'hF, ir_got);
      c0 = tot_cap;
      u0 = tot_udr;
      scan_dr(32'h000000A5, 8, 1'b0, dr_got);
      check("bypass_stream", 64'(dr_got[7:0]), 64'h4A);
      check("bypass_no_capture", 64'(tot_cap - c0), 64'h0);
      check("bypass_no_update", 64'(tot_udr - u0), 64'h0);

      // Five tms=1 edges from SHIFT_IR reach reset; one more edge there restores BYPASS
      scan_ir(4'h3, ir_got);
      check("five_tms_preload", 64'(jtag_instruction), 64'h3);
      tick(1'b1, 1'b0, 1'b0, b);
      tick(1'b1, 1'b0, 1'b0, b);
      tick(1'b0, 1'b0, 1'b0, b);
      tick(1'b0, 1'b0, 1'b0, b);
      repeat (5) tick(1'b1, 1'b1, 1'b0, b);
      tick(1'b1, 1'b0, 1'b0, b);
      check("five_tms_instruction", 64'(jtag_instruction), 64'hF);
      tick(1'b0, 1'b0, 1'b0, b);

      // Random traffic against the model
      for (int n = 0; n < 600; n++) begin
         if (m_state == S_IDLE || m_state == S_RESET) data_capture_val = $urandom;
         tick(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 59) == 0), b);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL timeout: simulation did not complete, required summary");
      $fatal(1);
   end

endmodule
